id_operand_stage: RTL
=====================

// Module: id_operand_stage
// PURPOSE
//  Decode/operand stage of the 5-stage MIPS pipeline. Sits upstream of the 32x32 register file and downstream of IF.
//  Buffers one instruction from IF and drives the register-file read addresses.
//  Resolves RAW hazards by bypass or stall, then registers operands, PC, instruction and destination into the EX pipeline register.
// PARAMETERS
//  RESET_PC  32'hBFC0_0000  value of id_pc while id_valid=0 after reset
// PORTS
//  clk          in   1   single clock; all state updates on posedge
//  rst_n        in   1   asynchronous, active-low reset
//  if_valid     in   1   IF presents an instruction
//  if_ready     out  1   stage accepts; transfer when if_valid&&if_ready
//  if_inst      in   32  instruction word
//  if_pc        in   32  PC of if_inst
//  rf_raddr1    out  5   register-file read port 1 address (rs)
//  rf_raddr2    out  5   register-file read port 2 address (rt)
//  rf_rdata1    in   32  register-file read data 1 (combinational, $0 reads 0)
//  rf_rdata2    in   32  register-file read data 2
//  ex_dst_vld   in   1   EX instruction writes a register
//  ex_dst       in   5   EX destination
//  ex_is_load   in   1   EX instruction is a load (result not yet available)
//  ex_result    in   32  EX ALU result
//  mem_dst_vld  in   1   MEM instruction writes a register
//  mem_dst      in   5   MEM destination
//  mem_result   in   32  MEM result (load data already aligned)
//  wb_wen       in   1   WB write enable (same net as register-file wen)
//  wb_waddr     in   5   WB write address
//  wb_wdata     in   32  WB write data
//  id_valid     out  1   EX pipeline register holds a valid instruction
//  id_ready     in   1   EX accepts; transfer when id_valid&&id_ready
//  id_pc,id_inst out 32  registered PC / instruction
//  id_op1,id_op2 out 32  registered resolved rs / rt values
//  id_dst       out  5   registered destination; 0 when none
// BEHAVIOUR
//  Reset (rst_n=0, async): state=EMPTY, id_valid=0, id_pc=RESET_PC, id_inst=0, id_op1=id_op2=0, id_dst=0; if_ready=1 after release.
//  Input buffer ib_{valid,inst,pc}; rf_raddr1=ib_inst[25:21], rf_raddr2=ib_inst[20:16] (combinational, 0 when !ib_valid).
//  Dest decode: opcode 0 -> rd; JAL -> 31; ADDIU/SLTI/SLTIU/ANDI/ORI/XORI/LUI/LW/LB/LBU/LH/LHU -> rt; else 0. $0 dest forced 0.
//  Source match: src!=0 && vld && dst==src. Register 0 never matches and always yields 0.
//  FSM: EMPTY (ib empty) | DECODE (ib full, no hazard) | STALL (ib full, hazard).
//   EMPTY -> DECODE/STALL on IF transfer; DECODE -> STALL when hazard appears;
//   STALL -> DECODE when hazard clears.
//   DECODE with id_ready||!id_valid: load out regs; go to EMPTY unless refilled the same cycle (stays DECODE/STALL).
//  if_ready = !ib_valid || (state==DECODE && (id_ready||!id_valid)); IF fill and ID drain in one cycle sustain 1 instr/cycle.
//  id_valid: set on out-reg load; cleared when id_valid&&id_ready and no new load. STALL with id_ready inserts bubble (id_valid=0).
//  Out regs hold value while id_valid&&!id_ready (no change to any id_* output).
//  Latency: IF transfer at edge N -> id_valid at edge N+1 when hazard-free.
//  Simultaneous WB write to a source reg: WB data wins over rf_rdata (register file has no internal bypass).
// CONFIGURATION
//  ID_FORWARDING_EN defined: per operand priority EX > MEM > WB > rf_rdata.
//   Hazard only when an EX match has ex_is_load=1 (one-cycle load-use stall).
//  ID_FORWARDING_EN undefined: any EX or MEM match is a hazard (stall).
//   A WB match still uses wb_wdata. Operand = WB or rf_rdata only.
// STRUCTURE
//  mips_pkg: opcode/funct localparams, REG_ZERO=5'd0, REG_RA=5'd31, FSM state encoding (ID_EMPTY/ID_DECODE/ID_STALL).
//  Sub-module id_bypass_mux: one instance per operand.
//   Inputs: src, rf data, EX/MEM/WB triplets. Outputs: value, hazard.
// TESTING
//  1 rst_n low mid-STALL -> id_valid=0, id_pc=BFC00000 immediately (async); first instr after release reaches id_valid in 1 cycle.
//  2 Back-to-back ADDU $3,$1,$2 / ADDU $4,$3,$3 with id_ready=1 -> no stall (fwd on); id_op1=id_op2=EX result of first.
//    Fwd off: 2 stall cycles, then wb_wdata used.
//  3 LW $5,0($1) then ADDU $6,$5,$0 -> exactly one bubble (id_valid=0 one cycle); then id_op1=mem_result.
//  4 ADDU $0,$1,$2 then ADDU $7,$0,$0 -> id_dst=0, no stall, id_op1=id_op2=0.
//  5 WB writes $8=32'hDEADBEEF the cycle ORI $9,$8,0 decodes, rf_rdata1=stale 0 -> id_op1=DEADBEEF.
//  6 id_ready held 0 for 3 cycles with if_valid=1 -> id_* stable, if_ready=0 after buffer fills, no instruction lost or duplicated.

Source files
------------

// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mips_pkg
// Purpose  : Opcode/funct encodings, architectural register names, ID-stage
//            FSM encoding and destination-register decode for the MIPS core.
// Revision : 1.0 - initial release
// ============================================================================
package mips_pkg;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_ADDIU   = 6'h09;
    localparam logic [5:0] OP_SLTI    = 6'h0A;
    localparam logic [5:0] OP_SLTIU   = 6'h0B;
    localparam logic [5:0] OP_ANDI    = 6'h0C;
    localparam logic [5:0] OP_ORI     = 6'h0D;
    localparam logic [5:0] OP_XORI    = 6'h0E;
    localparam logic [5:0] OP_LUI     = 6'h0F;
    localparam logic [5:0] OP_LB      = 6'h20;
    localparam logic [5:0] OP_LH      = 6'h21;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_LBU     = 6'h24;
    localparam logic [5:0] OP_LHU     = 6'h25;

    localparam logic [5:0] FN_ADDU    = 6'h21;
    localparam logic [5:0] FN_SUBU    = 6'h23;

    localparam logic [4:0] REG_ZERO   = 5'd0;
    localparam logic [4:0] REG_RA     = 5'd31;

    typedef enum logic [1:0] {
        ID_EMPTY  = 2'd0,
        ID_DECODE = 2'd1,
        ID_STALL  = 2'd2
    } id_state_e;

    // A zero register field naturally yields REG_ZERO, i.e. "no destination".
    function automatic logic [4:0] dest_reg(input logic [31:0] inst);
        logic [4:0] d;
        d = REG_ZERO;
        case (inst[31:26])
            OP_SPECIAL: d = inst[15:11];
            OP_JAL:     d = REG_RA;
            OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI,
            OP_LW, OP_LB, OP_LBU, OP_LH, OP_LHU:
                        d = inst[20:16];
            default:    d = REG_ZERO;
        endcase
        return d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/id_bypass_mux.sv
`default_nettype none
// ============================================================================
// Module   : id_bypass_mux
// Purpose  : Resolves one source operand against EX/MEM/WB producers and
//            flags a RAW hazard. Forwarding selected by ID_FORWARDING_EN.
// Revision : 1.0 - initial release
// ============================================================================
module id_bypass_mux
    import mips_pkg::*;
(
    input  logic [4:0]  src_i,
    input  logic [31:0] rf_data_i,
    input  logic        ex_vld_i,
    input  logic [4:0]  ex_dst_i,
    input  logic        ex_is_load_i,
    input  logic [31:0] ex_data_i,
    input  logic        mem_vld_i,
    input  logic [4:0]  mem_dst_i,
    input  logic [31:0] mem_data_i,
    input  logic        wb_vld_i,
    input  logic [4:0]  wb_dst_i,
    input  logic [31:0] wb_data_i,
    output logic [31:0] value_o,
    output logic        hazard_o
);

    logic ex_hit;
    logic mem_hit;
    logic wb_hit;

    assign ex_hit  = (src_i != REG_ZERO) && ex_vld_i  && (ex_dst_i  == src_i);
    assign mem_hit = (src_i != REG_ZERO) && mem_vld_i && (mem_dst_i == src_i);
    assign wb_hit  = (src_i != REG_ZERO) && wb_vld_i  && (wb_dst_i  == src_i);

`ifdef ID_FORWARDING_EN
    always_comb begin
        value_o  = rf_data_i;
        hazard_o = 1'b0;
        if (src_i == REG_ZERO) begin
            value_o = '0;
        end else if (ex_hit) begin
            // A load in EX has only its address; the consumer must wait a cycle.
            value_o  = ex_data_i;
            hazard_o = ex_is_load_i;
        end else if (mem_hit) begin
            value_o = mem_data_i;
        end else if (wb_hit) begin
            value_o = wb_data_i;
        end
    end
`else
    logic unused_fwd;
    assign unused_fwd = ^{ex_is_load_i, ex_data_i, mem_data_i};

    always_comb begin
        value_o  = rf_data_i;
        hazard_o = 1'b0;
        if (src_i == REG_ZERO) begin
            value_o = '0;
        end else begin
            hazard_o = ex_hit || mem_hit;
            if (wb_hit) begin
                value_o = wb_data_i;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: rtl/id_operand_stage.sv
`default_nettype none
// ============================================================================
// Module   : id_operand_stage
// Purpose  : MIPS decode/operand stage: one-entry IF buffer, RAW bypass/stall,
//            EX pipeline register. Optional forwarding via ID_FORWARDING_EN.
// Revision : 1.0 - initial release
// ============================================================================
module id_operand_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_valid,
    output logic        if_ready,
    input  logic [31:0] if_inst,
    input  logic [31:0] if_pc,
    output logic [4:0]  rf_raddr1,
    output logic [4:0]  rf_raddr2,
    input  logic [31:0] rf_rdata1,
    input  logic [31:0] rf_rdata2,
    input  logic        ex_dst_vld,
    input  logic [4:0]  ex_dst,
    input  logic        ex_is_load,
    input  logic [31:0] ex_result,
    input  logic        mem_dst_vld,
    input  logic [4:0]  mem_dst,
    input  logic [31:0] mem_result,
    input  logic        wb_wen,
    input  logic [4:0]  wb_waddr,
    input  logic [31:0] wb_wdata,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_pc,
    output logic [31:0] id_inst,
    output logic [31:0] id_op1,
    output logic [31:0] id_op2,
    output logic [4:0]  id_dst
);

    id_state_e   state_q,    state_d;
    logic [31:0] ib_inst_q,  ib_inst_d;
    logic [31:0] ib_pc_q,    ib_pc_d;
    logic        id_valid_q, id_valid_d;
    logic [31:0] id_pc_q,    id_pc_d;
    logic [31:0] id_inst_q,  id_inst_d;
    logic [31:0] id_op1_q,   id_op1_d;
    logic [31:0] id_op2_q,   id_op2_d;
    logic [4:0]  id_dst_q,   id_dst_d;

    logic        ib_valid;
    logic [31:0] op1_val;
    logic [31:0] op2_val;
    logic        haz1;
    logic        haz2;
    logic        hazard;
    logic        load_out;
    logic        fill;

    assign ib_valid  = (state_q != ID_EMPTY);
    assign rf_raddr1 = ib_valid ? ib_inst_q[25:21] : REG_ZERO;
    assign rf_raddr2 = ib_valid ? ib_inst_q[20:16] : REG_ZERO;

    id_bypass_mux u_byp_rs (
        .src_i        (rf_raddr1),
        .rf_data_i    (rf_rdata1),
        .ex_vld_i     (ex_dst_vld),
        .ex_dst_i     (ex_dst),
        .ex_is_load_i (ex_is_load),
        .ex_data_i    (ex_result),
        .mem_vld_i    (mem_dst_vld),
        .mem_dst_i    (mem_dst),
        .mem_data_i   (mem_result),
        .wb_vld_i     (wb_wen),
        .wb_dst_i     (wb_waddr),
        .wb_data_i    (wb_wdata),
        .value_o      (op1_val),
        .hazard_o     (haz1)
    );

    id_bypass_mux u_byp_rt (
        .src_i        (rf_raddr2),
        .rf_data_i    (rf_rdata2),
        .ex_vld_i     (ex_dst_vld),
        .ex_dst_i     (ex_dst),
        .ex_is_load_i (ex_is_load),
        .ex_data_i    (ex_result),
        .mem_vld_i    (mem_dst_vld),
        .mem_dst_i    (mem_dst),
        .mem_data_i   (mem_result),
        .wb_vld_i     (wb_wen),
        .wb_dst_i     (wb_waddr),
        .wb_data_i    (wb_wdata),
        .value_o      (op2_val),
        .hazard_o     (haz2)
    );

    // Hazard is judged against this cycle's producers, so the load decision
    // uses it directly; state_q records whether the held instruction stalled.
    assign hazard   = ib_valid && (haz1 || haz2);
    assign load_out = ib_valid && !hazard && (id_ready || !id_valid_q);
    assign if_ready = !ib_valid || load_out;
    assign fill     = if_valid && if_ready;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ID_EMPTY: begin
                if (fill) state_d = ID_DECODE;
            end
            ID_DECODE, ID_STALL: begin
                if (load_out)    state_d = fill ? ID_DECODE : ID_EMPTY;
                else if (hazard) state_d = ID_STALL;
                else             state_d = ID_DECODE;
            end
            default: state_d = ID_EMPTY;
        endcase
    end

    always_comb begin
        ib_inst_d  = ib_inst_q;
        ib_pc_d    = ib_pc_q;
        id_valid_d = id_valid_q;
        id_pc_d    = id_pc_q;
        id_inst_d  = id_inst_q;
        id_op1_d   = id_op1_q;
        id_op2_d   = id_op2_q;
        id_dst_d   = id_dst_q;
        if (fill) begin
            ib_inst_d = if_inst;
            ib_pc_d   = if_pc;
        end
        if (load_out) begin
            id_valid_d = 1'b1;
            id_pc_d    = ib_pc_q;
            id_inst_d  = ib_inst_q;
            id_op1_d   = op1_val;
            id_op2_d   = op2_val;
            id_dst_d   = dest_reg(ib_inst_q);
        end else if (id_ready) begin
            // Consumer took the entry (or stall bubble): only the valid drops.
            id_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ID_EMPTY;
            ib_inst_q  <= '0;
            ib_pc_q    <= '0;
            id_valid_q <= 1'b0;
            id_pc_q    <= RESET_PC;
            id_inst_q  <= '0;
            id_op1_q   <= '0;
            id_op2_q   <= '0;
            id_dst_q   <= REG_ZERO;
        end else begin
            state_q    <= state_d;
            ib_inst_q  <= ib_inst_d;
            ib_pc_q    <= ib_pc_d;
            id_valid_q <= id_valid_d;
            id_pc_q    <= id_pc_d;
            id_inst_q  <= id_inst_d;
            id_op1_q   <= id_op1_d;
            id_op2_q   <= id_op2_d;
            id_dst_q   <= id_dst_d;
        end
    end

    assign id_valid = id_valid_q;
    assign id_pc    = id_pc_q;
    assign id_inst  = id_inst_q;
    assign id_op1   = id_op1_q;
    assign id_op2   = id_op2_q;
    assign id_dst   = id_dst_q;

endmodule
`default_nettype wire
